fp_stream_extremum: RTL
=======================

// Module: fp_stream_extremum
// PURPOSE
// - Streaming max/min finder for a parametrised sign/exponent/mantissa float format (default 1/4/8 = 13 bits).
// - Consumes a packet of floats over a valid/ready stream delimited by in_last.
// - Returns the packet's extreme value and its position, also over valid/ready.
// - Sits after the fp comparators in the ch3 datapath examples; it is the sequential, configurable-width successor to the single-shot greater-than compare.
// PARAMETERS
// - EXP_W   4  exponent field width (bits)
// - MANT_W  8  mantissa field width (bits)
// - IDX_W   8  element-index counter width; the index wraps modulo 2**IDX_W
// - FP_W    (localparam) = 1+EXP_W+MANT_W; sign at [FP_W-1], exponent [FP_W-2:MANT_W], mantissa [MANT_W-1:0]
// PORTS
// - clk        in   1      clock, all state on rising edge
// - rst_n      in   1      asynchronous active-low reset
// - mode       in   1      0 = find max, 1 = find min; sampled on first beat of each packet
// - in_valid   in   1      input beat valid
// - in_ready   out  1      block can accept a beat
// - in_data    in   FP_W   input float
// - in_last    in   1      marks final beat of packet
// - out_valid  out  1      result valid
// - out_ready  in   1      downstream accepts result
// - out_data   out  FP_W   extreme value of packet
// - out_idx    out  IDX_W  zero-based position of out_data within packet
// BEHAVIOUR
// - Reset values: state=ACCUM, first=1, in_ready=1, out_valid=0, out_data=0, out_idx=0, count=0, mode_q=0. Reset mid-packet discards the partial packet; the next accepted beat starts a new packet.
// - Ordering (combinational, FP_W-generic): sign-magnitude compare.
//   - Positive beats negative.
//   - Same positive sign: larger {exp,mant} is greater.
//   - Same negative sign: smaller {exp,mant} is greater.
//   - +0 (0x0000) and -0 (sign only) compare EQUAL.
//   - No NaN/Inf special cases; all-ones exponent is an ordinary value.
// - States:
//   - ACCUM: in_ready=1, out_valid=0.
//   - HOLD: in_ready=0, out_valid=1.
// - Beat accepted (in_valid&&in_ready):
//   - first=1: best<=in_data, best_idx<=0, count<=1, mode_q<=mode, first<=0.
//   - first=0: replace best/best_idx with in_data/count only if strictly better (mode_q=0: in>best; mode_q=1: in<best). Ties keep the earliest index. count<=count+1 (wraps).
// - Accepted beat with in_last=1:
//   - The last beat's compare is included in the result.
//   - Next cycle: state=HOLD, out_valid=1, with out_data/out_idx = final best.
//   - Latency is 1 cycle from last-beat acceptance to out_valid.
//   - A single-beat packet (first and last together) yields that beat, idx 0.
// - HOLD:
//   - out_data/out_idx are stable while out_valid && !out_ready.
//   - On out_ready=1: next cycle state=ACCUM, first=1, out_valid=0.
//   - Minimum of one in_ready-low bubble between packets.
// - mode changes mid-packet are ignored (mode_q is held).
// - Packets longer than 2**IDX_W beats are legal; out_idx reports the position modulo 2**IDX_W.
// - in_data/in_last are ignored when in_valid=0. out_data/out_idx are don't-care-free: they hold their last result after a handshake.
// TESTING
// - Max, packet {0x0300,0x0480,0x1500(last)}, mode=0 -> 1 cycle after last: out_valid=1, out_data=0x0480, out_idx=1.
// - Same packet, mode=1 -> out_data=0x1500, out_idx=2. Also {0x1200,0x1500}, mode=0 -> 0x1200, idx 0.
// - Ties/zeros: {0x0200,0x0200}, mode=0 -> idx 0. {0x1000,0x0000}, mode=0 -> out_data=0x1000, idx 0 (+/-0 equal).
// - Backpressure: hold out_ready=0 for 3 cycles after result -> out_valid, out_data, out_idx unchanged; in_ready=0 throughout; one cycle after out_ready=1, in_ready=1.
// - Single beat {0x0A55,last}, and a mode toggle mid-packet -> single beat returns 0x0A55 idx 0; the toggled packet uses the first-beat mode.
// - Reset: assert rst_n=0 async after 2 beats of a packet -> out_valid=0 immediately. Next packet {0x0100(last)} -> 0x0100 idx 0.
// - Wrap: IDX_W=2 with a 6-beat packet whose max is at beat 5 -> out_idx=1.

Source files
------------

// File: rtl/fp_stream_extremum.sv
// Streaming max/min finder over valid/ready packets of sign/exponent/mantissa floats.
// Reports the extreme value of each packet and its zero-based position (modulo 2**IDX_W).
module fp_stream_extremum #(
  parameter int EXP_W  = 4,
  parameter int MANT_W = 8,
  parameter int IDX_W  = 8,
  localparam int FP_W  = 1 + EXP_W + MANT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FP_W-1:0]  out_data,
  output logic [IDX_W-1:0] out_idx
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state, state_nx;
  logic               first;
  logic               mode_q;
  logic [IDX_W-1:0]   count;
  logic [FP_W-1:0]    best;
  logic [IDX_W-1:0]   best_idx;

  logic               accept;
  logic               better;
  logic [FP_W-1:0]    best_nx;
  logic [IDX_W-1:0]   idx_nx;

  // Sign-magnitude ordering; +0 and -0 are equal, no special encodings.
  function automatic logic fp_gt(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
    logic [FP_W-2:0] ma;
    logic [FP_W-2:0] mb;
    ma = a[FP_W-2:0];
    mb = b[FP_W-2:0];
    if (ma == '0 && mb == '0)
      fp_gt = 1'b0;
    else if (a[FP_W-1] != b[FP_W-1])
      fp_gt = ~a[FP_W-1];
    else if (!a[FP_W-1])
      fp_gt = (ma > mb);
    else
      fp_gt = (ma < mb);
  endfunction

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    better  = mode_q ? fp_gt(best, in_data) : fp_gt(in_data, best);
    best_nx = best;
    idx_nx  = best_idx;
    if (first) begin
      best_nx = in_data;
      idx_nx  = '0;
    end else if (better) begin
      best_nx = in_data;
      idx_nx  = count;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM:   if (accept && in_last) state_nx = HOLD;
      HOLD:    if (out_ready)         state_nx = ACCUM;
      default: state_nx = ACCUM;
    endcase
  end

  // The result registers are separate from the running best so that
  // out_data/out_idx keep the previous packet's answer while a new one accumulates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      first    <= 1'b1;
      mode_q   <= 1'b0;
      count    <= '0;
      best     <= '0;
      best_idx <= '0;
      out_data <= '0;
      out_idx  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        best     <= best_nx;
        best_idx <= idx_nx;
        first    <= 1'b0;
        if (first) begin
          mode_q <= mode;
          count  <= IDX_W'(1);
        end else begin
          count  <= count + 1'b1;
        end
        if (in_last) begin
          out_data <= best_nx;
          out_idx  <= idx_nx;
        end
      end
      if (state == HOLD && out_ready)
        first <= 1'b1;
    end
  end

endmodule
